k2red_mulpipe: RTL and testbench

//  Elastic 2-stage pipelined 12x12 unsigned modular-multiply front end for Kyber (q = 3329).

---
 rtl/k2red_mulpipe_pkg.sv | 19 +
 rtl/k2red_mulpipe_if.sv | 33 +++
 rtl/k2red_mulpipe_stage.sv | 25 ++
 rtl/k2red_mulpipe.sv | 72 +++++++
 tb/tb_k2red_mulpipe.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/k2red_mulpipe_pkg.sv
// Shared constants and helpers for the Kyber k2red multiply/reduce datapath.
// The k2red reduction stage imports the same package, so both sides agree on widths.
package k2red_mulpipe_pkg;

   localparam int unsigned KQ     = 3329;
   localparam int unsigned KK     = 13;
   localparam int unsigned KM     = 8;
   localparam int unsigned COEF_W = 12;
   localparam int unsigned PROD_W = 24;

   typedef logic [COEF_W-1:0] coef_t;
   typedef logic [PROD_W-1:0] prod_t;

   // Debug-only flag: an operand lies outside [0, q-1].
   function automatic logic out_of_range(input coef_t a, input coef_t b, input int unsigned q);
      return ({20'd0, a} >= q) || ({20'd0, b} >= q);
   endfunction

endpackage

// File: rtl/k2red_mulpipe_if.sv
// Operand-in / product-out handshake bundle for k2red_mulpipe.
// The slave modport is the pipeline side; the master modport is the producer/consumer side.
interface k2red_mulpipe_if
   import k2red_mulpipe_pkg::*;
#(
   parameter int unsigned TAG_W = 8
) ();

   logic             in_vld;
   logic             in_rdy;
   coef_t            in_a;
   coef_t            in_b;
   logic [TAG_W-1:0] in_tag;
   logic             in_last;

   logic             out_vld;
   logic             out_rdy;
   prod_t            out_c;
   logic [TAG_W-1:0] out_tag;
   logic             out_last;
   logic             out_err;

   modport master (
      output in_vld, in_a, in_b, in_tag, in_last, out_rdy,
      input  in_rdy, out_vld, out_c, out_tag, out_last, out_err
   );

   modport slave (
      input  in_vld, in_a, in_b, in_tag, in_last, out_rdy,
      output in_rdy, out_vld, out_c, out_tag, out_last, out_err
   );

endinterface

// File: rtl/k2red_mulpipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data register that loads only on advance.
module k2_pipe_stage #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   input  logic          in_vld,
   input  logic [DW-1:0] in_data,
   output logic          out_vld,
   output logic [DW-1:0] out_data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
      end else if (adv) begin
         out_vld <= in_vld;
         // Data only moves with a real item, keeping the slot bit-stable across bubbles.
         if (in_vld) out_data <= in_data;
      end
   end

endmodule

// File: rtl/k2red_mulpipe.sv
// Elastic two-stage 12x12 multiply front end for Kyber; feeds raw products to k2red.
// Stage 1 holds operands, stage 2 holds the product; nothing follows the output registers.
module k2red_mulpipe
   import k2red_mulpipe_pkg::*;
#(
   parameter int unsigned Q     = KQ,
   parameter int unsigned TAG_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   k2red_mulpipe_if.slave       bus,
   output logic                 busy
);

   localparam int unsigned S1W = 2 + TAG_W + 2 * COEF_W;
   localparam int unsigned S2W = 2 + TAG_W + PROD_W;

   logic             v1, v2;
   logic             adv1, adv2;
   logic [S1W-1:0]   s1_d, s1_q;
   logic [S2W-1:0]   s2_d, s2_q;

   logic             s1_last, s1_err;
   logic [TAG_W-1:0] s1_tag;
   coef_t            s1_a, s1_b;
   prod_t            prod;

   // Backpressure ripples straight from out_rdy to in_rdy; there is no skid buffer.
   assign adv2       = !v2 || bus.out_rdy;
   assign adv1       = !v1 || adv2;
   assign bus.in_rdy = adv1;
   assign busy       = v1 || v2;

   assign s1_d = {bus.in_last, out_of_range(bus.in_a, bus.in_b, Q), bus.in_tag, bus.in_a, bus.in_b};

   k2_pipe_stage #(.DW(S1W)) u_s1 (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv1),
      .in_vld   (bus.in_vld),
      .in_data  (s1_d),
      .out_vld  (v1),
      .out_data (s1_q)
   );

   assign s1_last = s1_q[S1W-1];
   assign s1_err  = s1_q[S1W-2];
   assign s1_tag  = s1_q[2*COEF_W +: TAG_W];
   assign s1_a    = s1_q[COEF_W +: COEF_W];
   assign s1_b    = s1_q[0 +: COEF_W];

   // Full-width product: 3328*3328 still fits in 24 bits, and out-of-range pairs pass through too.
   assign prod = PROD_W'(s1_a) * PROD_W'(s1_b);
   assign s2_d = {s1_last, s1_err, s1_tag, prod};

   k2_pipe_stage #(.DW(S2W)) u_s2 (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv2),
      .in_vld   (v1),
      .in_data  (s2_d),
      .out_vld  (v2),
      .out_data (s2_q)
   );

   assign bus.out_vld  = v2;
   assign bus.out_last = s2_q[S2W-1];
   assign bus.out_err  = s2_q[S2W-2];
   assign bus.out_tag  = s2_q[PROD_W +: TAG_W];
   assign bus.out_c    = s2_q[0 +: PROD_W];

endmodule

// File: tb/tb_k2red_mulpipe.sv
// Self-checking bench for k2red_mulpipe: directed cases plus random traffic
// against a capacity-2 FIFO model of the elastic pipeline.
module tb_k2red_mulpipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int unsigned edges = 0;
   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [23:0] c;
      logic [7:0]  tag;
      logic        last;
      logic        err;
      int unsigned t;
   } exp_t;

   exp_t q[$];

   k2red_mulpipe_if #(.TAG_W(8)) bus ();

   k2red_mulpipe #(.Q(3329), .TAG_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   task automatic check(input string tg, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tg, got, exp, $time);
      end
   endtask

   // One cycle: drive inputs at the falling edge, check against the model, advance one edge.
   task automatic step(input logic v, input int unsigned a, input int unsigned b,
                       input logic [7:0] tg, input logic lst, input logic ordy);
      logic exp_vld, exp_rdy;
      exp_t e;
      bus.in_vld  = v;
      bus.in_a    = a[11:0];
      bus.in_b    = b[11:0];
      bus.in_tag  = tg;
      bus.in_last = lst;
      bus.out_rdy = ordy;
      #1;
      // A pair becomes visible one edge after it was accepted; capacity is two pairs.
      exp_vld = (q.size() > 0) && (edges > q[0].t);
      exp_rdy = (q.size() < 2) || ordy;
      check("out_vld", {31'd0, bus.out_vld}, {31'd0, exp_vld});
      check("in_rdy", {31'd0, bus.in_rdy}, {31'd0, exp_rdy});
      check("busy", {31'd0, busy}, {31'd0, q.size() > 0});
      if (exp_vld) begin
         check("out_c", {8'd0, bus.out_c}, {8'd0, q[0].c});
         check("out_tag", {24'd0, bus.out_tag}, {24'd0, q[0].tag});
         check("out_last", {31'd0, bus.out_last}, {31'd0, q[0].last});
         check("out_err", {31'd0, bus.out_err}, {31'd0, q[0].err});
         if (ordy) void'(q.pop_front());
      end
      if (v && exp_rdy) begin
         e.c    = 24'(a[11:0] * b[11:0]);
         e.tag  = tg;
         e.last = lst;
         e.err  = (a[11:0] >= 3329) || (b[11:0] >= 3329);
         e.t    = edges + 1;
         q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (q.size() > 0 && n < 20) begin
         step(1'b0, 0, 0, 8'd0, 1'b0, 1'b1);
         n++;
      end
      if (q.size() > 0) begin
         check("drain_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask

   task automatic do_reset(input int unsigned n);
      rst         = 1'b1;
      bus.in_vld  = 1'b1;
      bus.in_a    = 12'd13;
      bus.in_b    = 12'd256;
      bus.in_tag  = 8'd9;
      bus.in_last = 1'b1;
      bus.out_rdy = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      q.delete();
      check("rst_out_vld", {31'd0, bus.out_vld}, 32'd0);
      check("rst_out_c", {8'd0, bus.out_c}, 32'd0);
      check("rst_out_tag", {24'd0, bus.out_tag}, 32'd0);
      check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst        = 1'b0;
      bus.in_vld = 1'b0;
      #1;
      check("rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
   endtask

   initial begin
      bus.in_vld  = 1'b0;
      bus.in_a    = '0;
      bus.in_b    = '0;
      bus.in_tag  = '0;
      bus.in_last = 1'b0;
      bus.out_rdy = 1'b1;

      do_reset(3);
      @(negedge clk);

      // single pair, 2-cycle latency
      step(1'b1, 13, 256, 8'd5, 1'b0, 1'b1);
      step(1'b0, 0, 0, 8'd0, 1'b0, 1'b1);
      check("single_c", {8'd0, bus.out_c}, 32'd3328);
      drain();

      // extremes back-to-back
      step(1'b1, 3328, 3328, 8'd1, 1'b0, 1'b1);
      step(1'b1, 0, 3328, 8'd2, 1'b1, 1'b1);
      check("max_c", {8'd0, bus.out_c}, 32'd11075584);
      drain();

      // six pairs with out_rdy low for four cycles mid-stream
      begin
         int unsigned sent = 0;
         for (int i = 0; i < 16; i++) begin
            logic ordy;
            logic v;
            ordy = !(i >= 3 && i <= 6);
            v    = (sent < 6);
            if (v && ((q.size() < 2) || ordy)) begin
               step(1'b1, sent, sent + 1, 8'(10 + sent), sent == 5, ordy);
               sent++;
            end else begin
               step(v, sent, sent + 1, 8'(10 + sent), sent == 5, ordy);
            end
         end
         check("bp_sent", sent, 32'd6);
         drain();
      end

      // range flag
      step(1'b1, 3329, 2, 8'd20, 1'b0, 1'b1);
      step(1'b1, 3328, 1, 8'd21, 1'b0, 1'b1);
      check("range_err", {31'd0, bus.out_err}, 32'd1);
      check("range_c", {8'd0, bus.out_c}, 32'd6658);
      drain();

      // reset with two pairs in flight
      step(1'b1, 100, 200, 8'd30, 1'b0, 1'b0);
      step(1'b1, 300, 400, 8'd31, 1'b0, 1'b0);
      do_reset(1);
      @(negedge clk);
      step(1'b0, 0, 0, 8'd0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 8'd0, 1'b0, 1'b1);
      step(1'b1, 1234, 2345, 8'd32, 1'b1, 1'b1);
      drain();

      // random traffic, occasional out-of-range operands
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0,
              $urandom_range(0, 3340), $urandom_range(0, 3340),
              8'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1);
   end

endmodule
